// File: rtl/spi_flash_rd_ctrl.sv
// spi_flash_rd_ctrl: SPI mode-0 master that issues 03h READ and returns 32-bit little-endian words.
// Optional macro SPI_FLASH_RD_CTRL_CONT_EN keeps CSn low between words so sequential reads skip cmd/addr.
module spi_flash_rd_ctrl #(
    parameter int CLKDIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        spi_csn,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on any cycle with req_valid && req_ready, and req_ready
    // depends on the state register only. rsp_valid is a one-cycle pulse with no backpressure.

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_CSWAIT = 2'd2;
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
    localparam logic [1:0] ST_HOLD   = 2'd3;
`endif

    localparam logic [7:0] DIV_LAST  = 8'(CLKDIV - 1);
    localparam logic [8:0] WAIT_LAST = 9'(2 * CLKDIV - 1);

    logic [1:0]  state;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [8:0]  wait_cnt;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic        half_done;
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
    logic [23:0] addr_q;
    logic [23:0] next_addr;
    logic        restart;
`endif

    assign half_done = (div_cnt == DIV_LAST);
    // tx_sr empties to zero after the address bits, so MOSI is low for the whole data phase.
    assign spi_mosi  = tx_sr[31];
    assign dbg_state = state;

`ifdef SPI_FLASH_RD_CTRL_CONT_EN
    assign req_ready = (state == ST_IDLE) || (state == ST_HOLD);
`else
    assign req_ready = (state == ST_IDLE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            spi_csn   <= 1'b1;
            spi_sck   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
            addr_q    <= '0;
            next_addr <= '0;
            restart   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        spi_csn <= 1'b0;
                        tx_sr   <= {8'h03, req_addr};
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= ST_SHIFT;
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
                        addr_q  <= req_addr;
`endif
                    end
                end

                ST_SHIFT: begin
                    if (!half_done) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        spi_sck <= ~spi_sck;
                        if (!spi_sck) begin
                            // Rising SCK: MISO has been stable since the previous fall.
                            if (bit_cnt[5]) begin
                                rx_sr <= {rx_sr[30:0], spi_miso};
                            end
                        end else if (bit_cnt != 6'd63) begin
                            bit_cnt <= bit_cnt + 6'd1;
                            tx_sr   <= {tx_sr[30:0], 1'b0};
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
                            next_addr <= addr_q + 24'd4;
                            state     <= ST_HOLD;
`else
                            spi_csn   <= 1'b1;
                            wait_cnt  <= '0;
                            state     <= ST_CSWAIT;
`endif
                        end
                    end
                end

                ST_CSWAIT: begin
                    if (wait_cnt != WAIT_LAST) begin
                        wait_cnt <= wait_cnt + 9'd1;
                    end else begin
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
                        if (restart) begin
                            // Non-sequential request from HOLD: reissue the full 03h frame.
                            restart <= 1'b0;
                            spi_csn <= 1'b0;
                            tx_sr   <= {8'h03, addr_q};
                            bit_cnt <= '0;
                            div_cnt <= '0;
                            state   <= ST_SHIFT;
                        end else begin
                            state   <= ST_IDLE;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end
                end

`ifdef SPI_FLASH_RD_CTRL_CONT_EN
                ST_HOLD: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        div_cnt <= '0;
                        if (req_addr == next_addr) begin
                            bit_cnt <= 6'd32;
                            state   <= ST_SHIFT;
                        end else begin
                            spi_csn  <= 1'b1;
                            wait_cnt <= '0;
                            restart  <= 1'b1;
                            state    <= ST_CSWAIT;
                        end
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// tb_spi_flash_rd_ctrl: directed reads against a behavioural serial flash with a response scoreboard.
module tb_spi_flash_rd_ctrl;

    localparam int CLKDIV = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        spi_csn;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] held_exp;
    int          acc_cyc;
    int          last_rsp_cyc;
    logic        csn_at_rsp;

    logic [7:0]  mem [int];
    int          fl_cnt;
    logic [31:0] fl_cmd;
    logic [31:0] fl_last_cmd;
    int          csn_rises;
    int          csn_rise_cyc;
    int          last_high_width;
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
    logic        hold_valid;
    logic [23:0] hold_next;
`endif

    spi_flash_rd_ctrl #(.CLKDIV(CLKDIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_read(input logic [23:0] a);
        int waitc;
        int lat;
        waitc = 0;
        @(negedge clk);
        while (!req_ready && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: ready=%0b after %0d cycles, expected 1", req_ready, waitc);
            return;
        end
        lat = 128 * CLKDIV;
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
        if (hold_valid && a == hold_next) lat = 64 * CLKDIV;
        else if (hold_valid) lat = 2 * CLKDIV + 128 * CLKDIV;
        hold_valid = 1'b1;
        hold_next  = a + 24'd4;
`endif
        acc_cyc = cyc;
        exp_q.push_back(word_at(a));
        exp_cyc_q.push_back(cyc + 1 + lat);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 24'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_done: %0d responses outstanding after %0d cycles, expected 0", exp_q.size(), n);
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- flash model + SPI line monitor ----------------
    initial begin : flash_model
        int          fl_dcnt;
        logic [23:0] fl_base;
        logic [23:0] ba;
        logic [7:0]  b;
        logic        prev_sck, prev_csn, prev_mosi, prev_rst;
        fl_cnt = 0; fl_dcnt = 0; fl_base = '0; fl_cmd = '0; fl_last_cmd = '0;
        csn_rises = 0; csn_rise_cyc = 0; last_high_width = 0;
        prev_sck = 1'b0; prev_csn = 1'b1; prev_mosi = 1'b0; prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || spi_csn) begin
                fl_cnt = 0;
                fl_dcnt = 0;
                fl_cmd = '0;
            end else if (!prev_sck && spi_sck) begin
                if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], spi_mosi};
                else check("mosi_data_zero", {31'd0, spi_mosi}, 32'd0);
                fl_cnt++;
                if (fl_cnt == 32) begin
                    fl_last_cmd = fl_cmd;
                    fl_base = fl_cmd[23:0];
                    check("cmd_byte", {24'd0, fl_cmd[31:24]}, 32'h03);
                end
            end else if (prev_sck && !spi_sck && fl_cnt >= 32) begin
                ba = fl_base + 24'(fl_dcnt / 8);
                b = mem_byte(ba);
                spi_miso = b[7 - (fl_dcnt % 8)];
                fl_dcnt++;
            end
            if (rst_n && prev_rst) begin
                checks++;
                if (spi_mosi !== prev_mosi && !(prev_sck && !spi_sck) && !(prev_csn && !spi_csn)) begin
                    errors++;
                    $display("FAIL mosi_stable: mosi %0b -> %0b at cycle %0d without SCK fall or CSn fall", prev_mosi, spi_mosi, cyc);
                end
                if (!prev_csn && spi_csn) begin
                    csn_rises++;
                    csn_rise_cyc = cyc;
                end
                if (prev_csn && !spi_csn) last_high_width = cyc - csn_rise_cyc;
            end
            prev_sck = spi_sck; prev_csn = spi_csn; prev_mosi = spi_mosi; prev_rst = rst_n;
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin : compare
        logic [31:0] e;
        int          ec;
        held_exp = '0;
        last_rsp_cyc = 0;
        csn_at_rsp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_exp = '0;
            end else begin
                if (rsp_valid) begin
                    last_rsp_cyc = cyc;
                    csn_at_rsp = spi_csn;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: rsp_valid=1 data 0x%08h at cycle %0d, expected no response", rsp_rdata, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        ec = exp_cyc_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e);
                        check("rsp_cycle", 32'(cyc), 32'(ec));
                        held_exp = e;
                    end
                end else begin
                    if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_missing: no rsp_valid by cycle %0d, expected at cycle %0d", cyc, exp_cyc_q[0]);
                        void'(exp_q.pop_front());
                        void'(exp_cyc_q.pop_front());
                    end
                    check("rdata_hold", rsp_rdata, held_exp);
                end
                if (spi_csn) check("sck_idle_low", {31'd0, spi_sck}, 32'd0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int r0;
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        mem[3] = 8'hA1; mem[4] = 8'hB2; mem[5] = 8'hC3; mem[6] = 8'hD4;
        mem[32'h204] = 8'h55; mem[32'h205] = 8'h66; mem[32'h206] = 8'h77; mem[32'h207] = 8'h88;
        mem[32'hFFFFFC] = 8'hF0; mem[32'hFFFFFD] = 8'hF1; mem[32'hFFFFFE] = 8'hF2; mem[32'hFFFFFF] = 8'hF3;
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
        hold_valid = 1'b0;
        hold_next  = '0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_csn", {31'd0, spi_csn}, 32'd1);
        check("rst_sck", {31'd0, spi_sck}, 32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        #2 rst_n = 1'b1;
        #1 check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Aligned read, latency and command/address pinned by hand
        do_read(24'h000100);
        wait_done();
        check("t1_data_literal", rsp_rdata, 32'h44332211);
        check("t1_latency", 32'(last_rsp_cyc - acc_cyc), 32'd257);
        check("t1_mosi_cmd_addr", fl_last_cmd, 32'h03000100);

        // Unaligned read
        do_read(24'h000003);
        wait_done();
        check("t2_data_literal", rsp_rdata, 32'hD4C3B2A1);
`ifndef SPI_FLASH_RD_CTRL_CONT_EN
        check("t2_csn_high_at_rsp", {31'd0, csn_at_rsp}, 32'd1);
        do_read(24'h000010);
        do_read(24'h000014);
        wait_done();
        check("b2b_csn_gap_ok", {31'd0, (last_high_width >= 2 * CLKDIV)}, 32'd1);
`else
        // Sequential continuation
        do_read(24'h000200);
        wait_done();
        r0 = csn_rises;
        do_read(24'h000204);
        wait_done();
        check("t3_seq_latency", 32'(last_rsp_cyc - acc_cyc), 32'd129);
        check("t3_no_csn_rise", 32'(csn_rises), 32'(r0));
        check("t3_data_literal", rsp_rdata, 32'h88776655);
        check("t3_csn_low_at_rsp", {31'd0, csn_at_rsp}, 32'd0);

        // Non-sequential from HOLD
        do_read(24'h000300);
        wait_done();
        check("t4_csn_high_width", 32'(last_high_width), 32'd4);
        check("t4_cmd_reissued", fl_last_cmd, 32'h03000300);

        // Address wrap counts as sequential
        do_read(24'hFFFFFC);
        wait_done();
        check("t5_top_literal", rsp_rdata, 32'hF3F2F1F0);
        do_read(24'h000000);
        wait_done();
        check("t5_wrap_latency", 32'(last_rsp_cyc - acc_cyc), 32'd129);
        check("t5_wrap_literal", rsp_rdata, 32'hA1030201);
`endif

        // Reset in the middle of the address phase (bit 20)
        do_read(24'h000040);
        n = 0;
        while (fl_cnt < 21 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6_bit20_reached", {31'd0, (fl_cnt >= 21)}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_csn", {31'd0, spi_csn}, 32'd1);
        check("t6_rst_sck", {31'd0, spi_sck}, 32'd0);
        check("t6_rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t6_rst_rdata", rsp_rdata, 32'd0);
        exp_q.delete();
        exp_cyc_q.delete();
`ifdef SPI_FLASH_RD_CTRL_CONT_EN
        hold_valid = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("t6_ready_after_rst", {31'd0, req_ready}, 32'd1);
        do_read(24'h000100);
        wait_done();
        check("t6_data_literal", rsp_rdata, 32'h44332211);
        check("t6_latency", 32'(last_rsp_cyc - acc_cyc), 32'd257);

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
